liteeth_sram_fifo_ctrl: RTL

LITEETH_SRAM_FIFO_CTRL -- requirements
Module: liteeth_sram_fifo_ctrl

---
 rtl/liteeth_sram_fifo_ctrl.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/liteeth_sram_fifo_ctrl.sv
// liteeth_sram_fifo_ctrl: stream FIFO built around a 1W/1R SRAM macro.
// Write port 0 stores accepted sink words (byte-masked). Read port 0 prefetches into a
// two-entry output buffer so the source side can stream one word per cycle.
// Optional feature macro: LITEETH_SRAM_FIFO_WATERMARK_EN adds the level_max output.
module liteeth_sram_fifo_ctrl #(
    parameter int unsigned BITS       = 32,
    parameter int unsigned WORD_DEPTH = 384,
    parameter int unsigned ADDR_WIDTH = 9,
    parameter int unsigned NUM_BYTES  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  sink_valid,
    output logic                  sink_ready,
    input  logic [BITS-1:0]       sink_data,
    input  logic [NUM_BYTES-1:0]  sink_be,
    output logic                  source_valid,
    input  logic                  source_ready,
    output logic [BITS-1:0]       source_data,
    output logic [9:0]            level,
    output logic                  csb0,
    output logic                  web0,
    output logic [NUM_BYTES-1:0]  wmask0,
    output logic [ADDR_WIDTH-1:0] addr0,
    output logic [BITS-1:0]       din0,
    output logic                  csb1,
    output logic [ADDR_WIDTH-1:0] addr1,
    input  logic [BITS-1:0]       dout1
`ifdef LITEETH_SRAM_FIFO_WATERMARK_EN
    ,
    output logic [9:0]            level_max
`endif
);

    localparam int unsigned LevelW = 10;
    localparam logic [LevelW-1:0]     DepthL  = LevelW'(WORD_DEPTH);
    localparam logic [ADDR_WIDTH-1:0] LastPtr = ADDR_WIDTH'(WORD_DEPTH - 1);

    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [LevelW-1:0]     level_q, level_d;
    // Words written to the SRAM but not yet read-issued.
    logic [LevelW-1:0]     unread_q, unread_d;
    logic                  inflight_q, inflight_d;
    logic [1:0]            occ_q, occ_d;
    logic [BITS-1:0]       buf0_q, buf0_d;
    logic [BITS-1:0]       buf1_q, buf1_d;

    logic       wr_en;
    logic       rd_en;
    logic       pop;
    logic [1:0] used;

    // Handshakes, SRAM port drive and read-issue decision.
    always_comb begin
        sink_ready   = ~rst & (level_q != DepthL);
        wr_en        = sink_valid & sink_ready & (|sink_be);
        source_valid = ~rst & (occ_q != 2'd0);
        pop          = source_valid & source_ready;
        used         = occ_q + {1'b0, inflight_q};
        // A pop this cycle frees a buffer slot, so a read may issue even with two slots
        // committed; this is what sustains one word per cycle.
        rd_en        = ~rst & (unread_q != '0) & ((used < 2'd2) | pop);

        csb0         = ~wr_en;
        web0         = ~wr_en;
        wmask0       = wr_en ? sink_be : '0;
        addr0        = wr_ptr_q;
        din0         = sink_data;
        csb1         = ~rd_en;
        addr1        = rd_ptr_q;
        source_data  = buf0_q;
        level        = level_q;
    end

    // Next-state for pointers, counters and the output buffer.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        if (wr_en) begin
            wr_ptr_d = (wr_ptr_q == LastPtr) ? '0 : wr_ptr_q + ADDR_WIDTH'(1);
        end
        rd_ptr_d = rd_ptr_q;
        if (rd_en) begin
            rd_ptr_d = (rd_ptr_q == LastPtr) ? '0 : rd_ptr_q + ADDR_WIDTH'(1);
        end

        level_d    = level_q + LevelW'(wr_en) - LevelW'(pop);
        unread_d   = unread_q + LevelW'(wr_en) - LevelW'(rd_en);
        inflight_d = rd_en;

        occ_d  = occ_q;
        buf0_d = buf0_q;
        buf1_d = buf1_q;
        if (pop) begin
            buf0_d = buf1_q;
            occ_d  = occ_q - 2'd1;
        end
        // Read data from last cycle's issue lands in the first free slot.
        if (inflight_q) begin
            if (occ_d == 2'd0) begin
                buf0_d = dout1;
            end else begin
                buf1_d = dout1;
            end
            occ_d = occ_d + 2'd1;
        end
    end

    // State registers with synchronous reset; buffered and in-flight words are discarded.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            unread_q   <= '0;
            inflight_q <= 1'b0;
            occ_q      <= 2'd0;
            buf0_q     <= '0;
            buf1_q     <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            unread_q   <= unread_d;
            inflight_q <= inflight_d;
            occ_q      <= occ_d;
            buf0_q     <= buf0_d;
            buf1_q     <= buf1_d;
        end
    end

`ifdef LITEETH_SRAM_FIFO_WATERMARK_EN
    logic [LevelW-1:0] level_max_q, level_max_d;

    // Peak level tracker; bounded by the FIFO depth, so it saturates naturally.
    always_comb begin
        level_max_d = (level_d > level_max_q) ? level_d : level_max_q;
        level_max   = level_max_q;
    end

    // Peak level register.
    always_ff @(posedge clk) begin
        if (rst) begin
            level_max_q <= '0;
        end else begin
            level_max_q <= level_max_d;
        end
    end
`else
    // Watermark tracking not built.
`endif

endmodule
